// File: rtl/diffio_pkg.sv
// diffio_pkg: constants and types shared by the diffio pattern generator and checker.
//   - FSM state encodings (IDLE/LAUNCH/CHECK)
//   - default LFSR seed and feedback taps, kept in one place so generator and checker cannot drift
//   - diffio_lfsr_next(): one LFSR step
package diffio_pkg;

    localparam int unsigned DIFFIO_LFSR_W = 32;
    localparam int unsigned DIFFIO_TAP_HI = 30;
    localparam int unsigned DIFFIO_TAP_LO = 27;

    localparam logic [DIFFIO_LFSR_W-1:0] DIFFIO_DEFAULT_SEED = 32'hABCDEF01;

    typedef enum logic [3:0] {
        IDLE   = 4'b0000,
        LAUNCH = 4'b0001,
        CHECK  = 4'b0010
    } diffio_state_e;

    // Shift left, feedback from the two taps enters at bit 0.
    function automatic logic [DIFFIO_LFSR_W-1:0] diffio_lfsr_next(input logic [DIFFIO_LFSR_W-1:0] s);
        return {s[DIFFIO_LFSR_W-2:0], s[DIFFIO_TAP_HI] ^ s[DIFFIO_TAP_LO]};
    endfunction

endpackage

// File: rtl/diffio_lfsr32.sv
// diffio_lfsr32: 32-bit pattern LFSR with seed load and shift enable.
// Ports:
//   CLK, RST_N : clock, asynchronous active-low reset (register resets to SEED)
//   LOAD       : reload SEED (wins over SHIFT)
//   SHIFT      : advance one step
//   MSB        : current register bit 31 (the pattern bit)
module diffio_lfsr32
    import diffio_pkg::*;
#(
    parameter logic [31:0] SEED = DIFFIO_DEFAULT_SEED
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic LOAD,
    input  logic SHIFT,
    output logic MSB
);

    localparam int unsigned W = DIFFIO_LFSR_W;

    logic [W-1:0] lfsr_q;
    logic [W-1:0] lfsr_d;

    // Next-state: load has priority over shift.
    always_comb begin
        lfsr_d = lfsr_q;
        if (LOAD) begin
            lfsr_d = SEED;
        end else if (SHIFT) begin
            lfsr_d = diffio_lfsr_next(lfsr_q);
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign MSB = lfsr_q[W-1];

endmodule

// File: rtl/diffio_pattern_checker_sm.sv
// diffio_pattern_checker_sm: receive-side checker for the diffio LFSR pattern.
// Synchronizes BIT_IN, regenerates the LFSR locally and counts mismatches over
// NUM_BITS_TO_CHECK bits. Each bit spends one CLK_EN period in LAUNCH and one in
// CHECK, in lockstep with the generator.
// Ports:
//   CLK, RST_N     : clock, asynchronous active-low reset
//   CLK_EN         : advance enable for FSM, counter, LFSR and error count
//   START          : begin a run (accepted only in IDLE with CLK_EN high)
//   BIT_IN         : received pattern bit, asynchronous to CLK
//   BUSY           : run in progress
//   RESULT_VALID   : run finished, results stable until next accepted START
//   PASS           : RESULT_VALID with zero errors (combinational)
//   ERROR_COUNT    : saturating mismatch count
// Optional (macro DIFFIO_CHECKER_FIRST_ERR_EN):
//   FIRST_ERR_VALID, FIRST_ERR_INDEX : bit index of the first mismatch in the run
module diffio_pattern_checker_sm
    import diffio_pkg::*;
#(
    parameter int unsigned NUM_BITS_TO_CHECK = 1000,
    parameter logic [31:0] SEED              = DIFFIO_DEFAULT_SEED,
    parameter int unsigned SYNC_STAGES       = 2
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        CLK_EN,
    input  logic        START,
    input  logic        BIT_IN,
    output logic        BUSY,
    output logic        RESULT_VALID,
    output logic        PASS,
`ifdef DIFFIO_CHECKER_FIRST_ERR_EN
    output logic        FIRST_ERR_VALID,
    output logic [31:0] FIRST_ERR_INDEX,
`endif
    output logic [31:0] ERROR_COUNT
);

    localparam int unsigned CNT_W    = 32;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_BITS_TO_CHECK - 1);

    diffio_state_e          state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0]       err_q, err_d;
    logic                   busy_q, busy_d;
    logic                   rv_q, rv_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
`ifdef DIFFIO_CHECKER_FIRST_ERR_EN
    logic                   fev_q, fev_d;
    logic [CNT_W-1:0]       fidx_q, fidx_d;
`endif

    logic bit_s;
    logic exp_bit;
    logic lfsr_load;
    logic lfsr_shift;
    logic mismatch_c;

    diffio_lfsr32 #(
        .SEED (SEED)
    ) u_lfsr (
        .CLK   (CLK),
        .RST_N (RST_N),
        .LOAD  (lfsr_load),
        .SHIFT (lfsr_shift),
        .MSB   (exp_bit)
    );

    // Synchronizer runs every CLK regardless of CLK_EN.
    assign bit_s      = sync_q[SYNC_STAGES-1];
    assign mismatch_c = bit_s ^ exp_bit;

    // Next-state and output logic.
    always_comb begin
        sync_d     = {sync_q[SYNC_STAGES-2:0], BIT_IN};
        state_d    = state_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
        busy_d     = busy_q;
        rv_d       = rv_q;
        lfsr_load  = 1'b0;
        lfsr_shift = 1'b0;
`ifdef DIFFIO_CHECKER_FIRST_ERR_EN
        fev_d      = fev_q;
        fidx_d     = fidx_q;
`endif
        if (CLK_EN) begin
            case (state_q)
                IDLE: begin
                    if (START) begin
                        err_d   = '0;
                        rv_d    = 1'b0;
                        busy_d  = 1'b1;
                        state_d = LAUNCH;
`ifdef DIFFIO_CHECKER_FIRST_ERR_EN
                        fev_d   = 1'b0;
                        fidx_d  = '0;
`endif
                    end
                end
                LAUNCH: begin
                    busy_d  = 1'b1;
                    state_d = CHECK;
                end
                CHECK: begin
                    if (mismatch_c) begin
                        if (err_q != '1) begin
                            err_d = err_q + CNT_W'(1);
                        end
`ifdef DIFFIO_CHECKER_FIRST_ERR_EN
                        if (!fev_q) begin
                            fev_d  = 1'b1;
                            fidx_d = cnt_q;
                        end
`endif
                    end
                    if (cnt_q == CNT_LAST) begin
                        cnt_d     = '0;
                        lfsr_load = 1'b1;
                        rv_d      = 1'b1;
                        busy_d    = 1'b0;
                        state_d   = IDLE;
                    end else begin
                        cnt_d      = cnt_q + CNT_W'(1);
                        lfsr_shift = 1'b1;
                        busy_d     = 1'b1;
                        state_d    = LAUNCH;
                    end
                end
                default: begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            err_q   <= '0;
            busy_q  <= 1'b0;
            rv_q    <= 1'b0;
            sync_q  <= '0;
`ifdef DIFFIO_CHECKER_FIRST_ERR_EN
            fev_q   <= 1'b0;
            fidx_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            rv_q    <= rv_d;
            sync_q  <= sync_d;
`ifdef DIFFIO_CHECKER_FIRST_ERR_EN
            fev_q   <= fev_d;
            fidx_q  <= fidx_d;
`endif
        end
    end

    assign BUSY         = busy_q;
    assign RESULT_VALID = rv_q;
    assign ERROR_COUNT  = err_q;
    assign PASS         = rv_q && (err_q == '0);
`ifdef DIFFIO_CHECKER_FIRST_ERR_EN
    assign FIRST_ERR_VALID = fev_q;
    assign FIRST_ERR_INDEX = fidx_q;
`endif

endmodule

// File: tb/tb_diffio_pattern_checker_sm.sv
// Bench for diffio_pattern_checker_sm: a behavioural pattern generator drives
// BIT_IN in lockstep with the checker; expected results are queued at START and
// checked by a monitor when RESULT_VALID rises.
module tb_diffio_pattern_checker_sm;

    localparam int N = 1000;
    localparam logic [31:0] SEED_TB = 32'hABCDEF01;

    logic        CLK, RST_N, CLK_EN, START, BIT_IN;
    logic        BUSY, RESULT_VALID, PASS;
    logic [31:0] ERROR_COUNT;
`ifdef DIFFIO_CHECKER_FIRST_ERR_EN
    logic        FIRST_ERR_VALID;
    logic [31:0] FIRST_ERR_INDEX;
`endif

    diffio_pattern_checker_sm #(
        .NUM_BITS_TO_CHECK (N),
        .SEED              (SEED_TB),
        .SYNC_STAGES       (2)
    ) dut (
        .CLK             (CLK),
        .RST_N           (RST_N),
        .CLK_EN          (CLK_EN),
        .START           (START),
        .BIT_IN          (BIT_IN),
        .BUSY            (BUSY),
        .RESULT_VALID    (RESULT_VALID),
        .PASS            (PASS),
`ifdef DIFFIO_CHECKER_FIRST_ERR_EN
        .FIRST_ERR_VALID (FIRST_ERR_VALID),
        .FIRST_ERR_INDEX (FIRST_ERR_INDEX),
`endif
        .ERROR_COUNT     (ERROR_COUNT)
    );

    typedef struct {
        int errs;
        bit pass;
        bit fev;
        int fidx;
    } exp_t;

    exp_t exp_q[$];
    bit   ref_bits [N];
    bit   tx_bits  [N];
    bit   flip_bits[N];

    int n_cmp = 0;
    int n_mis = 0;
    int cyc = 0;
    int gj = 0;
    bit gen_active = 0;
    bit stall = 0;
    int start_cyc = 0;
    int done_cyc = 0;
    int n_done = 0;
    int done_target = 0;
    int en_cnt = 0;

    initial begin
        CLK = 1'b0;
        forever #10 CLK = ~CLK;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_mis++;
            $display("FAIL %s: got %0d required %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_cmp++;
        n_mis++;
        $display("FAIL %s: timeout waiting for DUT (t=%0t)", name, $time);
    endtask

    // Reference pattern straight from the seed and the shift rule.
    function automatic void build_ref();
        logic [31:0] s;
        s = SEED_TB;
        for (int k = 0; k < N; k++) begin
            ref_bits[k] = s[31];
            s = {s[30:0], s[30] ^ s[27]};
        end
    endfunction

    function automatic void build_tx(input bit inv, input bit tie0);
        for (int k = 0; k < N; k++)
            tx_bits[k] = tie0 ? 1'b0 : (ref_bits[k] ^ inv ^ flip_bits[k]);
    endfunction

    function automatic int errs_upto(input int m);
        int e;
        e = 0;
        for (int k = 0; k < m && k < N; k++)
            if (tx_bits[k] != ref_bits[k]) e++;
        return e;
    endfunction

    function automatic exp_t make_exp();
        exp_t x;
        x.errs = errs_upto(N);
        x.pass = (x.errs == 0);
        x.fev  = (x.errs != 0);
        x.fidx = 0;
        for (int k = N - 1; k >= 0; k--)
            if (tx_bits[k] != ref_bits[k]) x.fidx = k;
        return x;
    endfunction

    // CLK_EN: one CLK in four, frozen while stall is set.
    initial begin
        CLK_EN = 1'b0;
        forever begin
            @(negedge CLK);
            if (stall) begin
                CLK_EN = 1'b0;
            end else begin
                en_cnt = (en_cnt + 1) % 4;
                CLK_EN = (en_cnt == 0);
            end
        end
    end

    // Behavioural generator: bit k is presented for two CLK_EN periods from the
    // edge that enters that bit's assertion phase.
    initial begin
        BIT_IN = 1'b0;
        forever begin
            @(posedge CLK);
            cyc++;
            if (!RST_N) begin
                gen_active = 0;
            end else if (CLK_EN) begin
                if (gen_active) begin
                    gj++;
                    if (gj == 2 * N) gen_active = 0;
                end else if (START) begin
                    gen_active = 1;
                    gj = 0;
                    start_cyc = cyc;
                end
            end
            #1;
            BIT_IN = gen_active ? tx_bits[gj / 2] : 1'b0;
        end
    end

    // Monitor: on each RESULT_VALID rise, pop the queued expectation and compare.
    initial begin
        bit   rv_prev;
        exp_t e;
        rv_prev = 1'b0;
        forever begin
            @(posedge CLK);
            #2;
            if (RESULT_VALID && !rv_prev) begin
                done_cyc = cyc;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_mis++;
                    $display("FAIL unexpected_result: RESULT_VALID rose with nothing queued (t=%0t)", $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("error_count", ERROR_COUNT, 32'(e.errs));
                    chk("pass", 32'(PASS), 32'(e.pass));
`ifdef DIFFIO_CHECKER_FIRST_ERR_EN
                    chk("first_err_valid", 32'(FIRST_ERR_VALID), 32'(e.fev));
                    chk("first_err_index", FIRST_ERR_INDEX, 32'(e.fidx));
`endif
                end
                n_done++;
            end
            rv_prev = RESULT_VALID;
        end
    end

    task automatic do_start();
        int budget;
        exp_q.push_back(make_exp());
        done_target = n_done + 1;
        @(negedge CLK);
        START = 1'b1;
        budget = 0;
        do begin
            @(posedge CLK);
            budget++;
        end while (!CLK_EN && budget < 20);
        @(negedge CLK);
        START = 1'b0;
    endtask

    task automatic wait_gj(input int target);
        int budget;
        budget = 0;
        do begin
            @(posedge CLK);
            #2;
            budget++;
        end while (gj < target && budget < 12 * N);
        if (gj < target) timeout_fail("wait_bit_index");
    endtask

    task automatic wait_done(input bit check_dur);
        int budget;
        budget = 0;
        while (n_done < done_target && budget < 12 * N) begin
            @(posedge CLK);
            budget++;
        end
        #3;
        if (n_done < done_target) begin
            timeout_fail("run_done");
        end else if (check_dur) begin
            chk("run_length_cycles", 32'(done_cyc - start_cyc), 32'(8 * N));
        end
    endtask

    task automatic clear_flips();
        for (int k = 0; k < N; k++) flip_bits[k] = 1'b0;
    endtask

    initial begin
        START = 1'b0;
        RST_N = 1'b0;
        build_ref();
        clear_flips();
        build_tx(0, 0);
        repeat (3) @(posedge CLK);
        #1;
        chk("reset_busy", 32'(BUSY), 32'd0);
        chk("reset_result_valid", 32'(RESULT_VALID), 32'd0);
        chk("reset_pass", 32'(PASS), 32'd0);
        chk("reset_error_count", ERROR_COUNT, 32'd0);
        @(negedge CLK);
        RST_N = 1'b1;
        repeat (4) @(negedge CLK);

        // Clean loopback.
        build_tx(0, 0);
        do_start();
        wait_done(1);
        chk("result_valid_held", 32'(RESULT_VALID), 32'd1);

        // Inverted loopback: every bit wrong.
        build_tx(1, 0);
        do_start();
        wait_done(1);

        // Single flipped bit at index 5.
        clear_flips();
        flip_bits[5] = 1'b1;
        build_tx(0, 0);
        do_start();
        wait_done(0);

        // BIT_IN tied low: errors equal the number of ones in the reference.
        clear_flips();
        build_tx(0, 1);
        do_start();
        wait_done(0);

        // START while busy at bit 300 must not disturb the run or its length.
        build_tx(0, 0);
        do_start();
        wait_gj(600);
        @(negedge CLK);
        START = 1'b1;
        repeat (8) @(negedge CLK);
        START = 1'b0;
        chk("busy_after_restart_attempt", 32'(BUSY), 32'd1);
        wait_done(1);

        // Reset at bit 500 aborts the run.
        clear_flips();
        flip_bits[3] = 1'b1;
        build_tx(0, 0);
        do_start();
        wait_gj(1000);
        @(negedge CLK);
        RST_N = 1'b0;
        @(posedge CLK);
        #1;
        chk("abort_busy", 32'(BUSY), 32'd0);
        chk("abort_result_valid", 32'(RESULT_VALID), 32'd0);
        chk("abort_pass", 32'(PASS), 32'd0);
        chk("abort_error_count", ERROR_COUNT, 32'd0);
`ifdef DIFFIO_CHECKER_FIRST_ERR_EN
        chk("abort_first_err_valid", 32'(FIRST_ERR_VALID), 32'd0);
`endif
        exp_q.delete();
        done_target = n_done;
        repeat (3) @(negedge CLK);
        RST_N = 1'b1;
        repeat (4) @(negedge CLK);
        chk("abort_stays_idle", 32'(BUSY), 32'd0);

        // Fresh run with random flips and a 50-CLK CLK_EN stall mid-run.
        for (int k = 0; k < N; k++)
            flip_bits[k] = ($urandom_range(0, 49) == 0);
        build_tx(0, 0);
        do_start();
        wait_gj(700 + 2 * $urandom_range(0, 50));
        #1;
        stall = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(posedge CLK);
            #1;
            chk("stall_busy", 32'(BUSY), 32'd1);
            chk("stall_error_count", ERROR_COUNT, 32'(errs_upto(gj / 2)));
        end
        #2;
        stall = 1'b0;
        wait_done(0);

        // Same random pattern inverted: complementary error count.
        build_tx(1, 0);
        do_start();
        wait_done(1);

        chk("no_leftover_expectations", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
